// File: rtl/oddeven_counter.sv
// oddeven_counter: free-running counter stepping through even or odd values per mode, re-aligning parity in one cycle.
module oddeven_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  // Parity already matches the mode: advance by two; otherwise step once to realign.
  always_comb w_next = r_count + ((r_count[0] == mode) ? WIDTH'(2) : WIDTH'(1));
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_count <= '0;
    else        r_count <= w_next;
  assign count = r_count;
endmodule

// File: tb/tb_oddeven_counter.sv
// tb_oddeven_counter: scoreboard bench for oddeven_counter (WIDTH=16 and WIDTH=4 instances).
module tb_oddeven_counter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mode = 1'b1;
  logic        mode4 = 1'b1;
  logic [15:0] count16;
  logic [3:0]  count4;
  int unsigned q16[$];
  int unsigned q4[$];
  int unsigned m16 = 0;
  int unsigned m4 = 0;
  int n_cmp = 0;
  int n_bad = 0;

  oddeven_counter #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .mode(mode), .count(count16));
  oddeven_counter #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .mode(mode4), .count(count4));

  always #5 clk = ~clk;

  // Reference: the next value is the following integer (mod 2^w), bumped once more if its parity is wrong.
  function automatic int unsigned ref_next(int unsigned c, bit m, int w);
    longint unsigned span = longint'(1) << w;
    longint unsigned n = (longint'(c) + 1) % span;
    if (n % 2 != longint'(m)) n = (n + 1) % span;
    return int'(n);
  endfunction

  task automatic check(string name, int unsigned act, int unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q16.size() > 0) check("count16", count16, q16.pop_front());
    if (q4.size() > 0)  check("count4", count4, q4.pop_front());
  end

  task automatic step(bit m, bit r);
    @(negedge clk);
    mode  = m;
    reset = r;
    m16 = r ? ref_next(m16, m, 16) : 0;
    m4  = r ? ref_next(m4, 1'b1, 4) : 0;
    q16.push_back(m16);
    q4.push_back(m4);
  endtask

  task automatic async_rst();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst16", count16, 0);
    check("async_rst4", count4, 0);
    m16 = 0;
    m4  = 0;
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("reset16", count16, 0);
    check("reset4", count4, 0);
    repeat (5) step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    async_rst();
    repeat (5) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_rst();
      step(1'($urandom_range(0, 1)), $urandom_range(0, 19) != 0);
    end
    step(1'b0, 1'b0);
    for (int i = 0; i < 40000 && m16 != 65532; i++) step(1'b0, 1'b1);
    check("preload_even", m16, 65532);
    repeat (4) step(1'b0, 1'b1);
    for (int i = 0; i < 40000 && m16 != 65533; i++) step(1'b1, 1'b1);
    check("preload_odd", m16, 65533);
    repeat (4) step(1'b1, 1'b1);
    @(posedge clk);
    #3;
    check("drained", q16.size() + q4.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/oddeven_counter.md
ODDEVEN_COUNTER -- requirements
Module: oddeven_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning counter width in bits (minimum 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted, 1 = run).
REQ-004 The block SHALL have port mode, input, 1 bit: counting mode (1 = odd sequence, 0 = even sequence).
REQ-005 The block SHALL have port count, output, WIDTH bits: the current counter value, driven directly from a register.

Function
REQ-006 While reset=1, on each rising clk edge the count register SHALL load a next value determined by mode and the current count.
REQ-007 With mode=0 and count even, the next count SHALL be count+2.
REQ-008 With mode=1 and count odd, the next count SHALL be count+2.
REQ-009 If the parity of count does not match mode, the next count SHALL be count+1, which aligns it to the requested parity in one cycle.
REQ-010 All arithmetic SHALL be unsigned modulo 2^WIDTH with no saturation. For WIDTH=16: 65534 -> 0 in even mode, and 65535 -> 1 in odd mode.
REQ-011 mode SHALL be sampled on every rising edge. A mode change takes effect on the next edge with no extra latency, using REQ-009 alignment.
REQ-012 The latency SHALL be one clock: the output value reflects the edge just taken, with no pipeline stages.
REQ-013 The block SHALL have no handshake, enable, or overflow output; it counts every clock while out of reset.
REQ-014 count SHALL never be X/Z after the first reset assertion.

Reset
REQ-015 When reset=0, count SHALL go to 0 immediately, with no dependence on clk, and hold 0 while reset stays 0 regardless of mode or clock.
REQ-016 The reset value SHALL be 0 in both modes. In odd mode, the first edge after release yields 1 per REQ-009.
REQ-017 Reset asserted mid-count SHALL clear count to 0 within the same cycle. The first rising edge with reset=1 SHALL then resume from 0.
REQ-018 Deassertion is asynchronous to clk. The first counting update SHALL occur on the first rising edge at which reset=1.

Verification
REQ-019 Odd mode from reset:
- Stimulus: reset=0 for 50 ns with mode=1 (10 ns clock), then reset=1.
- Required response: count holds 0 during reset, then 1, 3, 5, 7, ... on successive edges (about 10 edges in 100 ns, reaching 19).
REQ-020 Reset mid-run and even mode:
- Stimulus: after REQ-019, reset=0 and mode=0 for 50 ns, then reset=1.
- Required response: count drops to 0 immediately without waiting for a clock edge, then 2, 4, 6, ... on successive edges.
REQ-021 Mode switch without reset:
- Stimulus: with count=6 in even mode, set mode=1.
- Required response: next count 7, then 9, 11.
- Stimulus: switch back to mode=0 at count 11.
- Required response: 12, 14.
REQ-022 Wrap-around:
- Stimulus: preload by counting (or force) count=65532 in even mode.
- Required response: 65534, 0, 2.
- Stimulus: odd mode from 65533.
- Required response: 65535, 1, 3.
REQ-023 Asynchronous reset timing:
- Stimulus: assert reset=0 between clock edges.
- Required response: count becomes 0 before the next rising edge and stays 0 through several edges.
REQ-024 Parameter check:
- Stimulus: instantiate WIDTH=4 in odd mode from reset.
- Required response: 1, 3, ..., 15, 1 (wrap).
